// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI mode-0 responder and its input conditioning.
package spi_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_e;

   // Mode 0: SCLK idles low; data is sampled on the rising edge and changed on the falling edge.
   localparam logic SCLK_IDLE_LEVEL = 1'b0;
   localparam logic SS_N_IDLE_LEVEL = 1'b1;

   localparam int         DEFAULT_DATA_W      = 8;
   localparam int         DEFAULT_SYNC_STAGES = 2;
   localparam logic [7:0] DEFAULT_IDLE_WORD   = 8'h00;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with rise/fall detection on the
// synchronised level registered once more.
module spi_sync_edge
   import spi_pkg::*;
#(
   parameter int   STAGES    = DEFAULT_SYNC_STAGES,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level_o = sync_q[STAGES-1];
   assign rise_o  = level_o & ~prev_q;
   assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 slave: oversamples the pin-facing bus in the clk domain, deserialises MOSI
// into rx_data and serialises MISO from a one-word TX holding buffer.
module spi_responder
   import spi_pkg::*;
#(
   parameter int                DATA_W      = DEFAULT_DATA_W,
   parameter int                SYNC_STAGES = DEFAULT_SYNC_STAGES,
   parameter logic [DATA_W-1:0] IDLE_WORD   = DEFAULT_IDLE_WORD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk,
   input  logic              ss_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_abort,
   output logic              tx_underrun
);

   localparam int                CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   logic sclk_level_unused, sclk_rise, sclk_fall;
   logic ss_level, ss_rise, ss_fall;
   logic mosi_level, mosi_rise_unused, mosi_fall_unused;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SCLK_IDLE_LEVEL)) u_sync_sclk (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (sclk),
      .level_o (sclk_level_unused),
      .rise_o  (sclk_rise),
      .fall_o  (sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SS_N_IDLE_LEVEL)) u_sync_ss (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (ss_n),
      .level_o (ss_level),
      .rise_o  (ss_rise),
      .fall_o  (ss_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (mosi),
      .level_o (mosi_level),
      .rise_o  (mosi_rise_unused),
      .fall_o  (mosi_fall_unused)
   );

   spi_state_e        state_q;
   logic [CNT_W-1:0]  bit_cnt_q;
   logic [DATA_W-1:0] tx_shift_q;
   logic [DATA_W-2:0] rx_shift_q;
   logic [DATA_W-1:0] buf_q;
   logic              buf_full_q;
   logic [DATA_W-1:0] rx_data_q;
   logic              rx_valid_q;
   logic              miso_oe_q;
   logic              frame_done_q;
   logic              frame_abort_q;
   logic              tx_underrun_q;

   logic              sclk_rise_ok, sclk_fall_ok;
   logic              tx_write;
   logic              load_word;
   logic [DATA_W-1:0] rx_word;

   // SCLK edges only count while the slave is selected, so a deselect that coincides
   // with an edge always wins.
   assign sclk_rise_ok = sclk_rise & ~ss_level;
   assign sclk_fall_ok = sclk_fall & ~ss_level;
   assign tx_write     = tx_valid & ~buf_full_q;
   assign load_word    = ((state_q == IDLE) && ss_fall) ||
                         ((state_q == ACTIVE) && sclk_fall_ok && (bit_cnt_q == '0));
   assign rx_word      = {rx_shift_q, mosi_level};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         bit_cnt_q     <= '0;
         tx_shift_q    <= '0;
         rx_shift_q    <= '0;
         buf_q         <= '0;
         buf_full_q    <= 1'b0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         miso_oe_q     <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_abort_q <= 1'b0;
         tx_underrun_q <= 1'b0;
      end else begin
         rx_valid_q    <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_abort_q <= 1'b0;
         tx_underrun_q <= 1'b0;

         if (tx_write) begin
            buf_q      <= tx_data;
            buf_full_q <= 1'b1;
         end

         // A write landing on a load from an empty buffer is kept for the next word.
         if (load_word) begin
            if (buf_full_q) begin
               tx_shift_q <= buf_q;
               buf_full_q <= 1'b0;
            end else begin
               tx_shift_q    <= IDLE_WORD;
               tx_underrun_q <= 1'b1;
            end
         end

         case (state_q)
            IDLE: begin
               if (ss_fall) begin
                  state_q    <= ACTIVE;
                  bit_cnt_q  <= '0;
                  rx_shift_q <= '0;
                  miso_oe_q  <= 1'b1;
               end
            end
            ACTIVE: begin
               if (ss_rise) begin
                  state_q       <= IDLE;
                  miso_oe_q     <= 1'b0;
                  bit_cnt_q     <= '0;
                  rx_shift_q    <= '0;
                  tx_shift_q    <= '0;
                  frame_done_q  <= (bit_cnt_q == '0);
                  frame_abort_q <= (bit_cnt_q != '0);
               end else begin
                  if (sclk_rise_ok) begin
                     rx_shift_q <= rx_word[DATA_W-2:0];
                     if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_q  <= '0;
                        rx_data_q  <= rx_word;
                        rx_valid_q <= 1'b1;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                     end
                  end
                  if (sclk_fall_ok && (bit_cnt_q != '0)) begin
                     tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign miso        = tx_shift_q[DATA_W-1];
   assign miso_oe     = miso_oe_q;
   assign tx_ready    = ~buf_full_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign busy        = (state_q == ACTIVE);
   assign frame_done  = frame_done_q;
   assign frame_abort = frame_abort_q;
   assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_responder.sv
// Self-checking bench for spi_responder: a behavioural SPI master drives frames while
// expected MISO/RX words are derived from the words the bench itself chose.
module tb_spi_responder;

   localparam logic [7:0] IDLE_WORD = 8'h00;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0;
   logic       ss_n = 1'b1;
   logic       mosi = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       miso, miso_oe, tx_ready, rx_valid, busy;
   logic       frame_done, frame_abort, tx_underrun;
   logic [7:0] rx_data;

   int nCompared = 0;
   int nMismatched = 0;

   int         rxCount = 0;
   int         urCount = 0;
   int         doneCount = 0;
   int         abortCount = 0;
   logic [7:0] rxSeen[$];

   logic [7:0] moArr[8];
   logic [7:0] miArr[8];
   logic [7:0] txArr[8];
   logic       midBusy, midOe;

   spi_responder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sclk        (sclk),
      .ss_n        (ss_n),
      .mosi        (mosi),
      .miso        (miso),
      .miso_oe     (miso_oe),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_abort (frame_abort),
      .tx_underrun (tx_underrun)
   );

   always #5 clk = ~clk;

   // Pulse monitor: counts every single-cycle event and records each received word.
   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         rxCount++;
         rxSeen.push_back(rx_data);
      end
      if (tx_underrun === 1'b1) urCount++;
      if (frame_done === 1'b1) doneCount++;
      if (frame_abort === 1'b1) abortCount++;
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic txWrite(input logic [7:0] d);
      int t = 0;
      while (tx_ready !== 1'b1 && t < 1000) begin
         waitClk(1);
         t++;
      end
      nCompared++;
      if (t >= 1000) begin
         nMismatched++;
         $display("[TB] FAIL tx_ready_wait: got tx_ready=%b want 1 within 1000 cycles", tx_ready);
      end
      tx_data  = d;
      tx_valid = 1'b1;
      waitClk(1);
      tx_valid = 1'b0;
   endtask

   // One master word, MSB first; MISO is sampled at the instant SCLK rises.
   task automatic sendWord(input logic [7:0] mo, input int half, input bit lastWord,
                           output logic [7:0] mi);
      for (int i = 7; i >= 0; i--) begin
         mosi = mo[i];
         waitClk(half);
         sclk  = 1'b1;
         mi[i] = miso;
         waitClk(half);
         if (i > 0 || !lastWord) sclk = 1'b0;
      end
   endtask

   task automatic runFrame(input int nw, input int half);
      logic [7:0] b;
      ss_n = 1'b0;
      waitClk(half);
      midBusy = busy;
      midOe   = miso_oe;
      for (int w = 0; w < nw; w++) begin
         sendWord(moArr[w], half, (w == nw - 1), b);
         miArr[w] = b;
      end
      sclk = 1'b0;
      ss_n = 1'b1;
      waitClk(8);
   endtask

   task automatic test_reset();
      int rx0;
      rx0 = rxCount;
      rst_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         sclk = ~sclk;
         waitClk(2);
         nCompared++;
         if ({miso, miso_oe, tx_ready, rx_valid, busy, frame_done, frame_abort, tx_underrun} !== 8'b0010_0000) begin
            nMismatched++;
            $display("[TB] FAIL reset_outputs: got miso=%b oe=%b rdy=%b rxv=%b busy=%b done=%b abort=%b ur=%b want 0,0,1,0,0,0,0,0",
                     miso, miso_oe, tx_ready, rx_valid, busy, frame_done, frame_abort, tx_underrun);
         end
      end
      nCompared++;
      if (rx_data !== 8'h00) begin
         nMismatched++;
         $display("[TB] FAIL reset_rx_data: got %h want 00", rx_data);
      end
      sclk = 1'b0;
      waitClk(2);
      rst_n = 1'b1;
      waitClk(6);
      nCompared++;
      if (rxCount - rx0 !== 0) begin
         nMismatched++;
         $display("[TB] FAIL reset_no_rx_valid: got %0d pulses want 0", rxCount - rx0);
      end
   endtask

   task automatic test_full_duplex();
      int rx0, d0, u0;
      rx0 = rxCount; d0 = doneCount; u0 = urCount;
      txWrite(8'hA5);
      moArr[0] = 8'h3C;
      runFrame(1, 5);
      nCompared++;
      if (midBusy !== 1'b1 || midOe !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL duplex_busy_oe: got busy=%b oe=%b want 1,1", midBusy, midOe);
      end
      nCompared++;
      if (miArr[0] !== 8'hA5) begin
         nMismatched++;
         $display("[TB] FAIL duplex_miso: got %h want a5", miArr[0]);
      end
      nCompared++;
      if (rxCount - rx0 !== 1 || rxSeen[rxSeen.size() - 1] !== 8'h3C) begin
         nMismatched++;
         $display("[TB] FAIL duplex_rx: got %0d pulses last=%h want 1 pulse 3c", rxCount - rx0, rxSeen[rxSeen.size() - 1]);
      end
      nCompared++;
      if (doneCount - d0 !== 1 || urCount - u0 !== 0) begin
         nMismatched++;
         $display("[TB] FAIL duplex_pulses: got done=%0d ur=%0d want 1,0", doneCount - d0, urCount - u0);
      end
      nCompared++;
      if (tx_ready !== 1'b1 || busy !== 1'b0 || miso_oe !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL duplex_end_state: got rdy=%b busy=%b oe=%b want 1,0,0", tx_ready, busy, miso_oe);
      end
   endtask

   // Random multi-word frame with the TX buffer refilled as soon as it empties.
   task automatic test_multi_word(input int half);
      int rx0, d0, u0, nw, base;
      nw = 5;
      rx0 = rxCount; d0 = doneCount; u0 = urCount;
      base = rxSeen.size();
      for (int i = 0; i < nw; i++) begin
         moArr[i] = 8'($urandom);
         txArr[i] = 8'($urandom);
      end
      txWrite(txArr[0]);
      fork
         runFrame(nw, half);
         begin
            for (int k = 1; k < nw; k++) txWrite(txArr[k]);
         end
      join
      for (int i = 0; i < nw; i++) begin
         nCompared++;
         if (miArr[i] !== txArr[i]) begin
            nMismatched++;
            $display("[TB] FAIL multi_miso[%0d]: got %h want %h (half=%0d)", i, miArr[i], txArr[i], half);
         end
      end
      nCompared++;
      if (rxCount - rx0 !== nw) begin
         nMismatched++;
         $display("[TB] FAIL multi_rx_count: got %0d want %0d", rxCount - rx0, nw);
      end else begin
         for (int i = 0; i < nw; i++) begin
            nCompared++;
            if (rxSeen[base + i] !== moArr[i]) begin
               nMismatched++;
               $display("[TB] FAIL multi_rx[%0d]: got %h want %h", i, rxSeen[base + i], moArr[i]);
            end
         end
      end
      nCompared++;
      if (urCount - u0 !== 0 || doneCount - d0 !== 1) begin
         nMismatched++;
         $display("[TB] FAIL multi_pulses: got ur=%0d done=%0d want 0,1", urCount - u0, doneCount - d0);
      end
   endtask

   task automatic test_underrun();
      int u0, rx0;
      u0 = urCount; rx0 = rxCount;
      moArr[0] = 8'($urandom);
      moArr[1] = 8'($urandom);
      runFrame(2, 5);
      for (int i = 0; i < 2; i++) begin
         nCompared++;
         if (miArr[i] !== IDLE_WORD) begin
            nMismatched++;
            $display("[TB] FAIL underrun_miso[%0d]: got %h want %h", i, miArr[i], IDLE_WORD);
         end
      end
      nCompared++;
      if (urCount - u0 !== 2 || rxCount - rx0 !== 2) begin
         nMismatched++;
         $display("[TB] FAIL underrun_pulses: got ur=%0d rx=%0d want 2,2", urCount - u0, rxCount - rx0);
      end
   endtask

   task automatic test_abort();
      logic [7:0] w1, w2, b;
      int a0, d0, rx0;
      w1 = 8'($urandom);
      w2 = 8'($urandom);
      a0 = abortCount; d0 = doneCount; rx0 = rxCount;
      txWrite(w1);
      ss_n = 1'b0;
      waitClk(4);
      txWrite(w2);
      b = 8'h00;
      for (int i = 7; i >= 5; i--) begin
         mosi = 1'($urandom);
         waitClk(4);
         sclk = 1'b1;
         b[i] = miso;
         waitClk(4);
         if (i > 5) sclk = 1'b0;
      end
      sclk = 1'b0;
      ss_n = 1'b1;
      waitClk(8);
      nCompared++;
      if (b[7:5] !== w1[7:5]) begin
         nMismatched++;
         $display("[TB] FAIL abort_partial_miso: got %b want %b", b[7:5], w1[7:5]);
      end
      nCompared++;
      if (abortCount - a0 !== 1 || doneCount - d0 !== 0 || rxCount - rx0 !== 0) begin
         nMismatched++;
         $display("[TB] FAIL abort_pulses: got abort=%0d done=%0d rx=%0d want 1,0,0",
                  abortCount - a0, doneCount - d0, rxCount - rx0);
      end
      nCompared++;
      if (tx_ready !== 1'b0 || miso_oe !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL abort_buffer_kept: got rdy=%b oe=%b want 0,0", tx_ready, miso_oe);
      end
      a0 = abortCount; d0 = doneCount; rx0 = rxCount;
      moArr[0] = 8'h81;
      runFrame(1, 5);
      nCompared++;
      if (rxCount - rx0 !== 1 || rxSeen[rxSeen.size() - 1] !== 8'h81) begin
         nMismatched++;
         $display("[TB] FAIL abort_next_rx: got %0d pulses last=%h want 1 pulse 81", rxCount - rx0, rxSeen[rxSeen.size() - 1]);
      end
      nCompared++;
      if (miArr[0] !== w2 || doneCount - d0 !== 1 || abortCount - a0 !== 0) begin
         nMismatched++;
         $display("[TB] FAIL abort_next_frame: got miso=%h done=%0d abort=%0d want %h,1,0",
                  miArr[0], doneCount - d0, abortCount - a0, w2);
      end
   endtask

   // Write lands on the very cycle the first word loads from an empty buffer (f_clk = 8*f_sclk).
   task automatic test_back_to_back();
      logic [7:0] c, b;
      int u0, rx0, base;
      c = 8'($urandom);
      moArr[0] = 8'($urandom);
      moArr[1] = 8'($urandom);
      u0 = urCount; rx0 = rxCount; base = rxSeen.size();
      ss_n = 1'b0;
      waitClk(2);
      tx_data  = c;
      tx_valid = 1'b1;
      waitClk(1);
      tx_valid = 1'b0;
      nCompared++;
      if (tx_underrun !== 1'b1 || tx_ready !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL coincide_load: got ur=%b rdy=%b want 1,0", tx_underrun, tx_ready);
      end
      waitClk(1);
      sendWord(moArr[0], 4, 1'b0, b);
      miArr[0] = b;
      sendWord(moArr[1], 4, 1'b1, b);
      miArr[1] = b;
      sclk = 1'b0;
      ss_n = 1'b1;
      waitClk(8);
      nCompared++;
      if (miArr[0] !== IDLE_WORD || miArr[1] !== c) begin
         nMismatched++;
         $display("[TB] FAIL coincide_miso: got %h,%h want %h,%h", miArr[0], miArr[1], IDLE_WORD, c);
      end
      nCompared++;
      if (urCount - u0 !== 1 || rxCount - rx0 !== 2) begin
         nMismatched++;
         $display("[TB] FAIL coincide_pulses: got ur=%0d rx=%0d want 1,2", urCount - u0, rxCount - rx0);
      end else begin
         nCompared++;
         if (rxSeen[base] !== moArr[0] || rxSeen[base + 1] !== moArr[1]) begin
            nMismatched++;
            $display("[TB] FAIL coincide_rx: got %h,%h want %h,%h", rxSeen[base], rxSeen[base + 1], moArr[0], moArr[1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_duplex();
      test_multi_word(5);
      test_multi_word(4);
      test_multi_word(6);
      test_underrun();
      test_abort();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
